id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Registered, parametrised instruction-decode stage for the RV32/RV64 core, sitting between fetch and execute and owning the ID/EX pipeline register. It decodes one instruction per cycle and resolves operands through N-way forwarding. It detects load-use hazards against its own ID/EX contents and inserts one bubble for each. Misaligned fetch, misaligned data-access and illegal-encoding traps are reported as registered exception records instead of being rewritten into jumps.

## Interface
- XLEN, 64, datapath width; 32 or 64 only
- NUM_FWD, 3, forwarding sources; index 0 is youngest and has highest priority
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush_i  in  1  kills the ID/EX register and any instruction offered this cycle
- if_valid_i  in  1  fetch offers an instruction
- if_ready_o  out  1  stage accepts an instruction this cycle
- inst_i  in  32  instruction word
- pc_i  in  XLEN  instruction PC
- rs1_addr_o, rs2_addr_o  out  5 each  regfile read addresses, equal to inst_i[19:15] and inst_i[24:20]
- rs1_data_i, rs2_data_i  in  XLEN each  regfile read data
- fwd_valid_i  in  NUM_FWD  forwarding entry k writes a register
- fwd_rd_addr_i  in  5*NUM_FWD  rd of entry k, at bits [5k+4:5k]
- fwd_wdata_i  in  XLEN*NUM_FWD  data of entry k
- out_valid_o  out  1  ID/EX register holds an instruction
- out_ready_i  in  1  EX consumes the register this cycle
- opcode_o 7, funct3_o 3, funct7_o 7, rd_addr_o 5, wreg_o 1  out  decoded fields
- rs1_data_o, rs2_data_o  out  XLEN  forwarded operands
- imm_o  out  XLEN  sign-extended immediate for the instruction's format (I/S/B/U/J)
- pc_o  out  XLEN  PC of the held instruction
- mem_req_o 1, mem_wen_o 1, mem_size_o 2, mem_addr_o XLEN, mem_wdata_o XLEN  out  data-cache request
- exc_valid_o 1, exc_cause_o XLEN, exc_tval_o XLEN  out  trap record
- stall_cnt_o  out  32  count of hazard bubbles inserted, saturating

## Operation
- Operand select, per source: addr 0 gives 0. Otherwise the lowest k with fwd_valid_i[k] and a matching rd supplies the value. Otherwise the regfile value is used.
- Load-use hazard: hz = out_valid_o & (opcode_o==LOAD) & rd_addr_o!=0 & (rd_addr_o==rs1_addr_o | rd_addr_o==rs2_addr_o (S/B/R only)) & if_valid_i.
- if_ready_o = !hz & (!out_valid_o | out_ready_i).
- Register update, in priority order:
  - flush_i: out_valid_o <= 0.
  - hz & out_ready_i: out_valid_o <= 0 (bubble); stall_cnt_o increments unless already 0xFFFF_FFFF.
  - if_valid_i & if_ready_o: capture the decoded instruction; out_valid_o <= 1.
  - out_ready_i: out_valid_o <= 0.
  - Otherwise: hold every output unchanged.
- Memory fields:
  - mem_addr = rs1 + simm12; the simm12 format depends on load or store.
  - mem_size comes from funct3: b=0, h=1, w=2, d=3.
  - mem_wdata = rs2 zero-extended from the access size.
  - mem_req = LOAD|STORE; mem_wen = STORE.
- Exceptions, checked in priority order; on any exception wreg_o=0, mem_req_o=0, exc_valid_o=1:
  - pc[1:0]!=0: cause 0, tval=pc.
  - Unknown opcode, or XLEN=32 with ld/lwu/sd: cause 2, tval = zero-extended inst.
  - Load addr not aligned to 2^size: cause 4, tval=addr.
  - Store addr not aligned to 2^size: cause 6, tval=addr.
- wreg_o = 0 for STORE and BRANCH, and whenever rd==0.
- Hazard detection and forwarding are fully combinational from inst_i, the ID/EX contents and the fwd inputs. The outputs are register-only.

## Timing
- Latency: 1 cycle from the if_valid_i & if_ready_o edge to out_valid_o.
- Throughput: 1 instruction per cycle without hazards; a load-use pair costs exactly 1 bubble.
- Stall behaviour: while out_valid_o & !out_ready_i, all outputs are stable and if_ready_o=0.
- Reset (rst low, asynchronous): every output register is 0, including out_valid_o, exc_valid_o and stall_cnt_o.
- Reset deasserts synchronously to clk; the first accept is possible in the first cycle after release.
- flush_i in the same cycle as a hazard or an accept: flush wins; nothing is captured and stall_cnt_o is unchanged.
- exc_valid_o travels with the instruction and clears with it; it is never set on a bubble.

## Test plan
- Back-to-back addi x1,x0,5 then add x2,x1,x1 with fwd[0]={1,x1,5}: second instruction gives rs1_data_o=rs2_data_o=5 one cycle after accept, with no bubble.
- ld x3,0(x4) held, then add x5,x3,x0 offered with out_ready_i=1: one cycle with out_valid_o=0, if_ready_o=0, stall_cnt_o becomes 1; the add is accepted the next cycle.
- sw x1,2(x2) with x2=0x1000: exc_valid_o=1, cause 6, tval=0x1002, mem_req_o=0.
- pc_i=0x8000_0002, any instruction: cause 0, tval=0x8000_0002, wreg_o=0.
- XLEN=32 instance with ld: cause 2, tval=inst.
- out_ready_i low for 3 cycles, then flush_i pulsed: outputs constant during the hold; out_valid_o=0 the cycle after the flush; an asynchronous reset mid-hold clears all outputs immediately.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage owning the ID/EX register: decodes one instruction per cycle,
// forwards operands, inserts load-use bubbles and records fetch/decode/alignment traps.
module id_stage_pipe #(
   parameter int XLEN    = 64,
   parameter int NUM_FWD = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic                    if_valid_i,
   output logic                    if_ready_o,
   input  logic [31:0]             inst_i,
   input  logic [XLEN-1:0]         pc_i,
   output logic [4:0]              rs1_addr_o,
   output logic [4:0]              rs2_addr_o,
   input  logic [XLEN-1:0]         rs1_data_i,
   input  logic [XLEN-1:0]         rs2_data_i,
   input  logic [NUM_FWD-1:0]      fwd_valid_i,
   input  logic [5*NUM_FWD-1:0]    fwd_rd_addr_i,
   input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [6:0]              opcode_o,
   output logic [2:0]              funct3_o,
   output logic [6:0]              funct7_o,
   output logic [4:0]              rd_addr_o,
   output logic                    wreg_o,
   output logic [XLEN-1:0]         rs1_data_o,
   output logic [XLEN-1:0]         rs2_data_o,
   output logic [XLEN-1:0]         imm_o,
   output logic [XLEN-1:0]         pc_o,
   output logic                    mem_req_o,
   output logic                    mem_wen_o,
   output logic [1:0]              mem_size_o,
   output logic [XLEN-1:0]         mem_addr_o,
   output logic [XLEN-1:0]         mem_wdata_o,
   output logic                    exc_valid_o,
   output logic [XLEN-1:0]         exc_cause_o,
   output logic [XLEN-1:0]         exc_tval_o,
   output logic [31:0]             stall_cnt_o
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rdAddr;
   logic [4:0]      rs1Addr;
   logic [4:0]      rs2Addr;
   logic            isLoad;
   logic            isStore;
   logic            isBranch;
   logic            knownOp;
   logic            usesRs2;
   logic            rv64Only;
   logic [31:0]     immI32;
   logic [31:0]     immS32;
   logic [31:0]     immB32;
   logic [31:0]     immU32;
   logic [31:0]     immJ32;
   logic [31:0]     imm32;
   logic [XLEN-1:0] rs1Fwd;
   logic [XLEN-1:0] rs2Fwd;
   logic [XLEN-1:0] memAddr;
   logic [XLEN-1:0] memWdata;
   logic [1:0]      memSize;
   logic            misaligned;
   logic            excD;
   logic [XLEN-1:0] causeD;
   logic [XLEN-1:0] tvalD;
   logic            hazard;

   logic            out_valid_q;
   logic [6:0]      opcode_q;
   logic [2:0]      funct3_q;
   logic [6:0]      funct7_q;
   logic [4:0]      rd_q;
   logic            wreg_q;
   logic [XLEN-1:0] rs1_q;
   logic [XLEN-1:0] rs2_q;
   logic [XLEN-1:0] imm_q;
   logic [XLEN-1:0] pc_q;
   logic            mem_req_q;
   logic            mem_wen_q;
   logic [1:0]      mem_size_q;
   logic [XLEN-1:0] mem_addr_q;
   logic [XLEN-1:0] mem_wdata_q;
   logic            exc_valid_q;
   logic [XLEN-1:0] exc_cause_q;
   logic [XLEN-1:0] exc_tval_q;
   logic [31:0]     stall_cnt_q;
   logic [31:0]     stall_cnt_d;

   assign opcode   = inst_i[6:0];
   assign funct3   = inst_i[14:12];
   assign rdAddr   = inst_i[11:7];
   assign rs1Addr  = inst_i[19:15];
   assign rs2Addr  = inst_i[24:20];
   assign isLoad   = (opcode == OP_LOAD);
   assign isStore  = (opcode == OP_STORE);
   assign isBranch = (opcode == OP_BRANCH);

   assign immI32 = {{20{inst_i[31]}}, inst_i[31:20]};
   assign immS32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign immB32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign immU32 = {inst_i[31:12], 12'b0};
   assign immJ32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   always_comb begin
      imm32   = '0;
      knownOp = 1'b1;
      usesRs2 = 1'b0;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR, OP_IMM32, OP_FENCE, OP_SYSTEM: imm32 = immI32;
         OP_STORE: begin
            imm32   = immS32;
            usesRs2 = 1'b1;
         end
         OP_BRANCH: begin
            imm32   = immB32;
            usesRs2 = 1'b1;
         end
         OP_REG, OP_REG32: usesRs2 = 1'b1;
         OP_LUI, OP_AUIPC: imm32 = immU32;
         OP_JAL:           imm32 = immJ32;
         default:          knownOp = 1'b0;
      endcase
   end

   // Walk from the oldest source to the youngest so that the lowest matching index wins.
   always_comb begin
      rs1Fwd = rs1_data_i;
      rs2Fwd = rs2_data_i;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_valid_i[k] && (fwd_rd_addr_i[5*k +: 5] == rs1Addr)) rs1Fwd = fwd_wdata_i[XLEN*k +: XLEN];
         if (fwd_valid_i[k] && (fwd_rd_addr_i[5*k +: 5] == rs2Addr)) rs2Fwd = fwd_wdata_i[XLEN*k +: XLEN];
      end
      if (rs1Addr == 5'd0) rs1Fwd = '0;
      if (rs2Addr == 5'd0) rs2Fwd = '0;
   end

   assign memSize = funct3[1:0];
   assign memAddr = rs1Fwd + XLEN'($signed(isStore ? immS32 : immI32));

   always_comb begin
      memWdata   = rs2Fwd;
      misaligned = 1'b0;
      case (memSize)
         2'd0: memWdata = XLEN'(rs2Fwd[7:0]);
         2'd1: begin
            memWdata   = XLEN'(rs2Fwd[15:0]);
            misaligned = memAddr[0];
         end
         2'd2: begin
            memWdata   = XLEN'(rs2Fwd[31:0]);
            misaligned = |memAddr[1:0];
         end
         default: misaligned = |memAddr[2:0];
      endcase
   end

   // ld, lwu and sd have no meaning on a 32-bit datapath and decode as illegal there.
   assign rv64Only = (XLEN == 32) &&
                     ((isLoad && ((funct3 == 3'd3) || (funct3 == 3'd6))) || (isStore && (funct3 == 3'd3)));

   always_comb begin
      excD   = 1'b0;
      causeD = '0;
      tvalD  = '0;
      if (pc_i[1:0] != 2'b00) begin
         excD   = 1'b1;
         causeD = XLEN'(0);
         tvalD  = pc_i;
      end else if (!knownOp || rv64Only) begin
         excD   = 1'b1;
         causeD = XLEN'(2);
         tvalD  = XLEN'(inst_i);
      end else if (isLoad && misaligned) begin
         excD   = 1'b1;
         causeD = XLEN'(4);
         tvalD  = memAddr;
      end else if (isStore && misaligned) begin
         excD   = 1'b1;
         causeD = XLEN'(6);
         tvalD  = memAddr;
      end
   end

   assign hazard = out_valid_q && (opcode_q == OP_LOAD) && (rd_q != 5'd0) && if_valid_i &&
                   ((rd_q == rs1Addr) || (usesRs2 && (rd_q == rs2Addr)));

   assign if_ready_o  = !hazard && (!out_valid_q || out_ready_i);
   assign stall_cnt_d = (stall_cnt_q == 32'hFFFF_FFFF) ? stall_cnt_q : stall_cnt_q + 32'd1;

   // Pipeline register; the exception flag always leaves together with out_valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         opcode_q    <= '0;
         funct3_q    <= '0;
         funct7_q    <= '0;
         rd_q        <= '0;
         wreg_q      <= 1'b0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
         mem_req_q   <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_size_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         exc_valid_q <= 1'b0;
         exc_cause_q <= '0;
         exc_tval_q  <= '0;
         stall_cnt_q <= '0;
      end else if (flush_i) begin
         out_valid_q <= 1'b0;
         exc_valid_q <= 1'b0;
      end else if (hazard && out_ready_i) begin
         out_valid_q <= 1'b0;
         exc_valid_q <= 1'b0;
         stall_cnt_q <= stall_cnt_d;
      end else if (if_valid_i && if_ready_o) begin
         out_valid_q <= 1'b1;
         opcode_q    <= opcode;
         funct3_q    <= funct3;
         funct7_q    <= inst_i[31:25];
         rd_q        <= rdAddr;
         wreg_q      <= !excD && !isStore && !isBranch && (rdAddr != 5'd0);
         rs1_q       <= rs1Fwd;
         rs2_q       <= rs2Fwd;
         imm_q       <= XLEN'($signed(imm32));
         pc_q        <= pc_i;
         mem_req_q   <= (isLoad || isStore) && !excD;
         mem_wen_q   <= isStore && !excD;
         mem_size_q  <= memSize;
         mem_addr_q  <= memAddr;
         mem_wdata_q <= memWdata;
         exc_valid_q <= excD;
         exc_cause_q <= causeD;
         exc_tval_q  <= tvalD;
      end else if (out_ready_i) begin
         out_valid_q <= 1'b0;
         exc_valid_q <= 1'b0;
      end
   end

   assign rs1_addr_o  = rs1Addr;
   assign rs2_addr_o  = rs2Addr;
   assign out_valid_o = out_valid_q;
   assign opcode_o    = opcode_q;
   assign funct3_o    = funct3_q;
   assign funct7_o    = funct7_q;
   assign rd_addr_o   = rd_q;
   assign wreg_o      = wreg_q;
   assign rs1_data_o  = rs1_q;
   assign rs2_data_o  = rs2_q;
   assign imm_o       = imm_q;
   assign pc_o        = pc_q;
   assign mem_req_o   = mem_req_q;
   assign mem_wen_o   = mem_wen_q;
   assign mem_size_o  = mem_size_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign exc_valid_o = exc_valid_q;
   assign exc_cause_o = exc_cause_q;
   assign exc_tval_o  = exc_tval_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a 64-bit instance for the main flow and a 32-bit
// instance running in lockstep to observe RV64-only encodings trapping.
module tb_id_stage_pipe;

   logic         clk;
   logic         rst;
   logic         flush;
   logic         ifValid;
   logic         outReady;
   logic [31:0]  inst;
   logic [63:0]  pc;
   logic [63:0]  rs1Data;
   logic [63:0]  rs2Data;
   logic [2:0]   fwdValid;
   logic [14:0]  fwdRd;
   logic [191:0] fwdData;

   logic         ifReady;
   logic [4:0]   rs1Addr, rs2Addr;
   logic         outValid, wreg, memReq, memWen, excValid;
   logic [6:0]   opcode, funct7;
   logic [2:0]   funct3;
   logic [4:0]   rdAddr;
   logic [1:0]   memSize;
   logic [63:0]  rs1Out, rs2Out, immOut, pcOut, memAddr, memWdata, excCause, excTval;
   logic [31:0]  stallCnt;

   logic         ifReady32;
   logic [4:0]   rs1Addr32, rs2Addr32;
   logic         outValid32, wreg32, memReq32, memWen32, excValid32;
   logic [6:0]   opcode32, funct7_32;
   logic [2:0]   funct3_32;
   logic [4:0]   rdAddr32;
   logic [1:0]   memSize32;
   logic [31:0]  rs1Out32, rs2Out32, immOut32, pcOut32, memAddr32, memWdata32, excCause32, excTval32;
   logic [31:0]  stallCnt32;

   int errors = 0;
   int checks = 0;
   logic [63:0] allOnes = '1;

   id_stage_pipe #(.XLEN(64), .NUM_FWD(3)) dut (
      .clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(ifValid), .if_ready_o(ifReady),
      .inst_i(inst), .pc_i(pc), .rs1_addr_o(rs1Addr), .rs2_addr_o(rs2Addr),
      .rs1_data_i(rs1Data), .rs2_data_i(rs2Data), .fwd_valid_i(fwdValid),
      .fwd_rd_addr_i(fwdRd), .fwd_wdata_i(fwdData), .out_valid_o(outValid),
      .out_ready_i(outReady), .opcode_o(opcode), .funct3_o(funct3), .funct7_o(funct7),
      .rd_addr_o(rdAddr), .wreg_o(wreg), .rs1_data_o(rs1Out), .rs2_data_o(rs2Out),
      .imm_o(immOut), .pc_o(pcOut), .mem_req_o(memReq), .mem_wen_o(memWen),
      .mem_size_o(memSize), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
      .exc_valid_o(excValid), .exc_cause_o(excCause), .exc_tval_o(excTval),
      .stall_cnt_o(stallCnt)
   );

   id_stage_pipe #(.XLEN(32), .NUM_FWD(3)) dut32 (
      .clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(ifValid), .if_ready_o(ifReady32),
      .inst_i(inst), .pc_i(pc[31:0]), .rs1_addr_o(rs1Addr32), .rs2_addr_o(rs2Addr32),
      .rs1_data_i(rs1Data[31:0]), .rs2_data_i(rs2Data[31:0]), .fwd_valid_i(3'b000),
      .fwd_rd_addr_i(15'd0), .fwd_wdata_i(96'd0), .out_valid_o(outValid32),
      .out_ready_i(outReady), .opcode_o(opcode32), .funct3_o(funct3_32), .funct7_o(funct7_32),
      .rd_addr_o(rdAddr32), .wreg_o(wreg32), .rs1_data_o(rs1Out32), .rs2_data_o(rs2Out32),
      .imm_o(immOut32), .pc_o(pcOut32), .mem_req_o(memReq32), .mem_wen_o(memWen32),
      .mem_size_o(memSize32), .mem_addr_o(memAddr32), .mem_wdata_o(memWdata32),
      .exc_valid_o(excValid32), .exc_cause_o(excCause32), .exc_tval_o(excTval32),
      .stall_cnt_o(stallCnt32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [63:0] p,
                                input logic [63:0] r1, input logic [63:0] r2,
                                input logic rdy, input logic fl);
      ifValid  = v;
      inst     = i;
      pc       = p;
      rs1Data  = r1;
      rs2Data  = r2;
      outReady = rdy;
      flush    = fl;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; ifValid = 1'b0; outReady = 1'b1; inst = '0; pc = '0;
      rs1Data = '0; rs2Data = '0; fwdValid = '0; fwdRd = '0; fwdData = '0;
      tick;
      tick;
      checkOutput("rst_valid", outValid, 0);
      checkOutput("rst_exc", excValid, 0);
      checkOutput("rst_stall", stallCnt, 0);
      checkOutput("rst_pc", pcOut, 0);
      checkOutput("rst_valid32", outValid32, 0);
      rst = 1'b1;

      // addi x1,x0,5 : x0 reads as zero even though the regfile returns junk
      applyStimulus(1, 32'h00500093, 64'h1000, 64'hDEAD, 64'hBEEF, 1, 0);
      checkOutput("addi_rs1a", rs1Addr, 0);
      checkOutput("addi_rs2a", rs2Addr, 5);
      checkOutput("addi_rdy", ifReady, 1);
      tick;
      checkOutput("addi_valid", outValid, 1);
      checkOutput("addi_op", opcode, 7'h13);
      checkOutput("addi_rd", rdAddr, 1);
      checkOutput("addi_wreg", wreg, 1);
      checkOutput("addi_imm", immOut, 5);
      checkOutput("addi_rs1d", rs1Out, 0);
      checkOutput("addi_rs2d", rs2Out, 64'hBEEF);
      checkOutput("addi_pc", pcOut, 64'h1000);
      checkOutput("addi_exc", excValid, 0);
      checkOutput("addi_mreq", memReq, 0);

      // add x2,x1,x1 with two forwarding hits; entry 0 must win
      fwdValid = 3'b011;
      fwdRd    = {5'd0, 5'd1, 5'd1};
      fwdData  = {64'd0, 64'd99, 64'd5};
      applyStimulus(1, 32'h00108133, 64'h1004, 64'h77, 64'h77, 1, 0);
      checkOutput("add_rdy", ifReady, 1);
      tick;
      checkOutput("add_rs1d", rs1Out, 5);
      checkOutput("add_rs2d", rs2Out, 5);
      checkOutput("add_rd", rdAddr, 2);
      checkOutput("add_op", opcode, 7'h33);
      checkOutput("add_imm", immOut, 0);
      checkOutput("add_stall", stallCnt, 0);
      fwdValid = 3'b000;

      // ld x3,0(x4) : legal on RV64, illegal encoding on the 32-bit instance
      applyStimulus(1, 32'h00023183, 64'h1008, 64'h2000, 64'h0, 1, 0);
      tick;
      checkOutput("ld_op", opcode, 7'h03);
      checkOutput("ld_mreq", memReq, 1);
      checkOutput("ld_mwen", memWen, 0);
      checkOutput("ld_msize", memSize, 3);
      checkOutput("ld_maddr", memAddr, 64'h2000);
      checkOutput("ld_exc", excValid, 0);
      checkOutput("ld_wreg", wreg, 1);
      checkOutput("ld32_exc", excValid32, 1);
      checkOutput("ld32_cause", excCause32, 2);
      checkOutput("ld32_tval", excTval32, 64'h00023183);
      checkOutput("ld32_wreg", wreg32, 0);
      checkOutput("ld32_mreq", memReq32, 0);

      // add x5,x3,x0 right behind the load : one bubble
      applyStimulus(1, 32'h000182B3, 64'h100C, 64'h33, 64'hAAAA, 1, 0);
      checkOutput("hz_rdy", ifReady, 0);
      tick;
      checkOutput("hz_valid", outValid, 0);
      checkOutput("hz_stall", stallCnt, 1);
      checkOutput("hz_exc", excValid, 0);
      checkOutput("hz_rdy_after", ifReady, 1);
      tick;
      checkOutput("hz2_valid", outValid, 1);
      checkOutput("hz2_rd", rdAddr, 5);
      checkOutput("hz2_rs1d", rs1Out, 64'h33);
      checkOutput("hz2_rs2d", rs2Out, 0);
      checkOutput("hz2_stall", stallCnt, 1);
      checkOutput("hz2_pc", pcOut, 64'h100C);

      // sw x1,2(x2) with x2=0x1000 : misaligned store
      applyStimulus(1, 32'h00112123, 64'h1010, 64'h1000, 64'h123456789ABCDEF0, 1, 0);
      tick;
      checkOutput("sw_exc", excValid, 1);
      checkOutput("sw_cause", excCause, 6);
      checkOutput("sw_tval", excTval, 64'h1002);
      checkOutput("sw_mreq", memReq, 0);
      checkOutput("sw_wreg", wreg, 0);
      checkOutput("sw_msize", memSize, 2);
      checkOutput("sw_wdata", memWdata, 64'h9ABCDEF0);
      checkOutput("sw_imm", immOut, 2);

      // lw x1,1(x4) with x4=0x1000 : misaligned load
      applyStimulus(1, 32'h00122083, 64'h1014, 64'h1000, 64'h0, 1, 0);
      tick;
      checkOutput("lw_exc", excValid, 1);
      checkOutput("lw_cause", excCause, 4);
      checkOutput("lw_tval", excTval, 64'h1001);

      // all-ones word : unknown opcode
      applyStimulus(1, 32'hFFFFFFFF, 64'h1018, 64'h0, 64'h0, 1, 0);
      tick;
      checkOutput("ill_cause", excCause, 2);
      checkOutput("ill_tval", excTval, 64'hFFFFFFFF);
      checkOutput("ill_wreg", wreg, 0);

      // misaligned fetch PC
      applyStimulus(1, 32'h00500093, 64'h80000002, 64'h0, 64'h0, 1, 0);
      tick;
      checkOutput("pc_exc", excValid, 1);
      checkOutput("pc_cause", excCause, 0);
      checkOutput("pc_tval", excTval, 64'h80000002);
      checkOutput("pc_wreg", wreg, 0);

      // addi x7,x0,-1, then EX stalls for three cycles and a flush ends the hold
      applyStimulus(1, 32'hFFF00393, 64'h3000, 64'h0, 64'h0, 1, 0);
      tick;
      checkOutput("neg_exc", excValid, 0);
      checkOutput("neg_imm", immOut, allOnes);
      checkOutput("neg_rd", rdAddr, 7);
      applyStimulus(1, 32'h00108133, 64'h3004, 64'h1, 64'h1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("hold_rdy", ifReady, 0);
         tick;
         checkOutput("hold_valid", outValid, 1);
         checkOutput("hold_rd", rdAddr, 7);
         checkOutput("hold_imm", immOut, allOnes);
         checkOutput("hold_pc", pcOut, 64'h3000);
      end
      applyStimulus(1, 32'h00108133, 64'h3004, 64'h1, 64'h1, 0, 1);
      tick;
      checkOutput("flush_valid", outValid, 0);
      checkOutput("flush_exc", excValid, 0);

      // flush in the same cycle as a load-use hazard: no bubble is counted
      applyStimulus(1, 32'h00023183, 64'h1008, 64'h2000, 64'h0, 1, 0);
      tick;
      checkOutput("ld2_valid", outValid, 1);
      applyStimulus(1, 32'h000182B3, 64'h100C, 64'h33, 64'h0, 1, 1);
      checkOutput("fhz_rdy", ifReady, 0);
      tick;
      checkOutput("fhz_valid", outValid, 0);
      checkOutput("fhz_stall", stallCnt, 1);

      // asynchronous reset in the middle of a hold
      applyStimulus(1, 32'h00500093, 64'h1000, 64'h0, 64'h0, 1, 0);
      tick;
      checkOutput("pre_valid", outValid, 1);
      applyStimulus(0, 32'h00500093, 64'h1000, 64'h0, 64'h0, 0, 0);
      tick;
      checkOutput("mid_valid", outValid, 1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("arst_valid", outValid, 0);
      checkOutput("arst_pc", pcOut, 0);
      checkOutput("arst_imm", immOut, 0);
      checkOutput("arst_rd", rdAddr, 0);
      checkOutput("arst_stall", stallCnt, 0);
      checkOutput("arst_valid32", outValid32, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
